// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types, widths and helpers for the BE MMU command queue
package bp_be_pkg;

    localparam int dword_width_gp  = 64;
    localparam int mem_op_width_gp = 4;

    typedef enum logic [mem_op_width_gp-1:0] {
        e_lb  = 4'd0,
        e_lh  = 4'd1,
        e_lw  = 4'd2,
        e_ld  = 4'd3,
        e_lbu = 4'd4,
        e_lhu = 4'd5,
        e_lwu = 4'd6,
        e_sb  = 4'd7,
        e_sh  = 4'd8,
        e_sw  = 4'd9,
        e_sd  = 4'd10
    } bp_be_mem_op_e;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_issue = 2'd1,
        e_wait  = 2'd2,
        e_miss  = 2'd3
    } bp_be_mmu_state_e;

    function automatic int bp_be_mmu_cmd_width(input int vaddr_width);
        return mem_op_width_gp + dword_width_gp + vaddr_width;
    endfunction

    function automatic int bp_be_mmu_resp_width();
        return dword_width_gp + 1;
    endfunction

    function automatic logic [1:0] bp_be_mem_op_size(input bp_be_mem_op_e op);
        case (op)
            e_lb, e_lbu, e_sb: return 2'd0;
            e_lh, e_lhu, e_sh: return 2'd1;
            e_lw, e_lwu, e_sw: return 2'd2;
            default:           return 2'd3;
        endcase
    endfunction

endpackage

`define BP_BE_DECLARE_MMU_STRUCTS(vaddr_width_mp) \
    typedef struct packed { \
        bp_be_pkg::bp_be_mem_op_e     mem_op; \
        logic [63:0]                  data; \
        logic [vaddr_width_mp-1:0]    vaddr; \
    } bp_be_mmu_cmd_s; \
    typedef struct packed { \
        logic cache_miss_v; \
    } bp_be_mmu_exception_s; \
    typedef struct packed { \
        logic [63:0]          data; \
        bp_be_mmu_exception_s exception; \
    } bp_be_mmu_resp_s;

// File: rtl/bp_be_mmu_cmd_fifo.sv
// rtl/bp_be_mmu_cmd_fifo.sv - circular command storage with head/tail pointers and occupancy count
module bp_be_mmu_cmd_fifo
  #(parameter int width_p = 8
   ,parameter int els_p   = 4
   ,localparam int ptr_width_lp   = $clog2(els_p)
   ,localparam int count_width_lp = $clog2(els_p+1))
  (input  logic                      clk_i
  ,input  logic                      reset_n_i
  ,input  logic                      clear_i
  ,input  logic                      push_i
  ,input  logic [width_p-1:0]        data_i
  ,input  logic                      pop_i
  ,output logic [width_p-1:0]        data_o
  ,output logic                      full_o
  ,output logic [count_width_lp-1:0] count_o);

  logic [width_p-1:0]        r_mem [els_p];
  logic [ptr_width_lp-1:0]   r_head;
  logic [ptr_width_lp-1:0]   r_tail;
  logic [count_width_lp-1:0] r_count;
  logic                      w_push;
  logic                      w_pop;

  // Pointers wrap at els_p, which need not be a power of two
  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == count_width_lp'(els_p));
  assign w_push  = push_i & ~full_o & ~clear_i;
  assign w_pop   = pop_i & (r_count != '0) & ~clear_i;
  assign data_o  = r_mem[r_head];
  assign count_o = r_count;

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_tail] <= data_i;
  end

  // Pointer and occupancy update; clear empties the queue outright
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= next_ptr(r_tail);
      if (w_pop)  r_head <= next_ptr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_be_mmu_cmd_queue.sv
// rtl/bp_be_mmu_cmd_queue.sv - mmu command queue issuing to D$ with miss replay; BP_BE_MISALIGN_CHECK_EN enables alignment faults
module bp_be_mmu_cmd_queue
    import bp_be_pkg::*;
    #(parameter int vaddr_width_p = 39
     ,parameter int els_p         = 4
     ,localparam int mmu_cmd_width_lp  = bp_be_mmu_cmd_width(vaddr_width_p)
     ,localparam int mmu_resp_width_lp = bp_be_mmu_resp_width()
     ,localparam int count_width_lp    = $clog2(els_p+1))
    (input  logic                         clk_i
    ,input  logic                         reset_n_i
    ,input  logic [mmu_cmd_width_lp-1:0]  mmu_cmd_i
    ,input  logic                         mmu_cmd_v_i
    ,output logic                         mmu_cmd_ready_o
    ,output logic                         overflow_o
    ,output logic [mmu_cmd_width_lp-1:0]  dcache_cmd_o
    ,output logic                         dcache_cmd_v_o
    ,input  logic                         dcache_cmd_ready_i
    ,input  logic [63:0]                  dcache_resp_data_i
    ,input  logic                         dcache_resp_v_i
    ,input  logic                         dcache_resp_miss_i
    ,input  logic                         fill_done_i
    ,input  logic                         flush_i
    ,output logic [mmu_resp_width_lp-1:0] mmu_resp_o
    ,output logic                         mmu_resp_v_o
    ,output logic                         misalign_o
    ,output logic [count_width_lp-1:0]    count_o);

    `BP_BE_DECLARE_MMU_STRUCTS(vaddr_width_p)

    bp_be_mmu_state_e            r_state;
    bp_be_mmu_state_e            w_state_n;
    logic                        r_flush_pend;
    logic                        w_flush_pend_n;
    logic [mmu_cmd_width_lp-1:0] w_head_raw;
    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_clear;
    logic                        w_cmd_v;
    logic                        w_resp_v;
    bp_be_mmu_resp_s             w_resp;
    logic                        w_more_than_one;

    assign w_push          = mmu_cmd_v_i & ~w_full & ~flush_i;
    assign mmu_cmd_ready_o = ~w_full;
    assign overflow_o      = reset_n_i & mmu_cmd_v_i & w_full;
    assign w_more_than_one = (count_o > count_width_lp'(1));

    bp_be_mmu_cmd_fifo
        #(.width_p(mmu_cmd_width_lp)
         ,.els_p  (els_p))
        u_fifo
            (.clk_i    (clk_i)
            ,.reset_n_i(reset_n_i)
            ,.clear_i  (w_clear)
            ,.push_i   (w_push)
            ,.data_i   (mmu_cmd_i)
            ,.pop_i    (w_pop)
            ,.data_o   (w_head_raw)
            ,.full_o   (w_full)
            ,.count_o  (count_o));

`ifdef BP_BE_MISALIGN_CHECK_EN
    bp_be_mmu_cmd_s w_head;
    logic           w_misaligned;
    logic           w_misalign_n;
    logic           r_misalign_v;

    assign w_head = w_head_raw;

    always_comb begin
        case (bp_be_mem_op_size(w_head.mem_op))
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = w_head.vaddr[0];
            2'd2:    w_misaligned = |w_head.vaddr[1:0];
            default: w_misaligned = |w_head.vaddr[2:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) r_misalign_v <= 1'b0;
        else            r_misalign_v <= w_misalign_n;
    end

    assign misalign_o   = r_misalign_v;
    assign mmu_resp_v_o = w_resp_v | r_misalign_v;
`else
    assign misalign_o   = 1'b0;
    assign mmu_resp_v_o = w_resp_v;
`endif

    assign dcache_cmd_o   = w_head_raw;
    assign dcache_cmd_v_o = w_cmd_v;
    assign mmu_resp_o     = w_resp;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= e_ready;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_flush_pend <= w_flush_pend_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_flush_pend_n = r_flush_pend;
        w_pop          = 1'b0;
        w_clear        = 1'b0;
        w_cmd_v        = 1'b0;
        w_resp_v       = 1'b0;
        w_resp         = '0;
`ifdef BP_BE_MISALIGN_CHECK_EN
        w_misalign_n   = 1'b0;
`endif
        case (r_state)
            e_ready: begin
                if (flush_i)            w_clear   = 1'b1;
                else if (count_o != '0) w_state_n = e_issue;
            end
            e_issue: begin
`ifdef BP_BE_MISALIGN_CHECK_EN
                if (w_misaligned) begin
                    w_pop        = 1'b1;
                    w_misalign_n = 1'b1;
                    if (flush_i) begin
                        w_clear   = 1'b1;
                        w_state_n = e_ready;
                    end else begin
                        w_state_n = w_more_than_one ? e_issue : e_ready;
                    end
                end else
`endif
                begin
                    w_cmd_v = 1'b1;
                    if (dcache_cmd_ready_i) begin
                        w_state_n      = e_wait;
                        w_flush_pend_n = r_flush_pend | flush_i;
                    end else if (flush_i) begin
                        w_clear   = 1'b1;
                        w_state_n = e_ready;
                    end
                end
            end
            e_wait: begin
                w_flush_pend_n = r_flush_pend | flush_i;
                if (dcache_resp_v_i) begin
                    w_resp_v = 1'b1;
                    if (dcache_resp_miss_i) begin
                        w_resp.exception.cache_miss_v = 1'b1;
                        w_state_n = e_miss;
                    end else begin
                        w_resp.data = dcache_resp_data_i;
                        w_pop       = 1'b1;
                        w_state_n   = w_more_than_one ? e_issue : e_ready;
                    end
                    if (w_flush_pend_n) begin
                        w_clear        = 1'b1;
                        w_flush_pend_n = 1'b0;
                        w_state_n      = e_ready;
                    end
                end
            end
            e_miss: begin
                w_flush_pend_n = r_flush_pend | flush_i;
                if (fill_done_i) begin
                    w_state_n = e_issue;
                    if (w_flush_pend_n) begin
                        w_clear        = 1'b1;
                        w_flush_pend_n = 1'b0;
                        w_state_n      = e_ready;
                    end
                end
            end
            default: w_state_n = e_ready;
        endcase
    end

endmodule
